// File: rtl/pla_sop_eval_if.sv
// ---------------------------------------------------------------------------
// pla_sop_eval_if
//   Bundles the cube-table configuration port, the input vector handshake and
//   the result handshake of pla_sop_eval.
//
//   Optional macro RESTRICT_EN adds rs_mask/rs_val (restriction subspace).
//
//   Signals (direction seen from the slave = evaluator):
//     cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask   in   table write
//     cfg_ready                                        out  write accepted
//     in_valid, in_x                                   in   input vector
//     in_ready                                         out  vector accepted
//     out_valid, out_y                                 out  result
//     out_ready                                        in   consumer ready
//     eval_cnt                                         out  completed results
//     rs_mask, rs_val (RESTRICT_EN only)               in   restriction
// ---------------------------------------------------------------------------
interface pla_sop_eval_if #(
    parameter int N_IN   = 8,
    parameter int N_CUBE = 16,
    parameter int N_OUT  = 1
);
    localparam int CAW = $clog2(N_CUBE);

    logic              cfg_we;
    logic [CAW-1:0]    cfg_addr;
    logic [N_IN-1:0]   cfg_care;
    logic [N_IN-1:0]   cfg_val;
    logic [N_OUT-1:0]  cfg_omask;
    logic              cfg_ready;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_x;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_y;
    logic [15:0]       eval_cnt;
`ifdef RESTRICT_EN
    logic [N_IN-1:0]   rs_mask;
    logic [N_IN-1:0]   rs_val;

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask,
        output in_valid, in_x, out_ready, rs_mask, rs_val,
        input  cfg_ready, in_ready, out_valid, out_y, eval_cnt
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask,
        input  in_valid, in_x, out_ready, rs_mask, rs_val,
        output cfg_ready, in_ready, out_valid, out_y, eval_cnt
    );
`else
    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask,
        output in_valid, in_x, out_ready,
        input  cfg_ready, in_ready, out_valid, out_y, eval_cnt
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_omask,
        input  in_valid, in_x, out_ready,
        output cfg_ready, in_ready, out_valid, out_y, eval_cnt
    );
`endif
endinterface

// File: rtl/pla_sop_eval.sv
// ---------------------------------------------------------------------------
// pla_sop_eval
//   Programmable sum-of-products evaluator. A runtime-loadable table of
//   N_CUBE cubes over N_IN inputs drives N_OUT outputs. One vector per cycle
//   flows through a 2-stage elastic valid/ready pipeline:
//     stage 1 : cube hit vector + snapshot of every cube's output mask
//     stage 2 : OR-plane result out_y
//
//   Optional macro RESTRICT_EN: adds rs_mask/rs_val; masked input variables
//   are forced to rs_val before matching (restriction of f to a subspace).
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset (clears table and pipeline)
//     bus    pla_sop_eval_if.slave (config, input and output handshakes)
// ---------------------------------------------------------------------------
module pla_sop_eval #(
    parameter int N_IN   = 8,
    parameter int N_CUBE = 16,
    parameter int N_OUT  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pla_sop_eval_if.slave  bus
);

    logic [N_IN-1:0]  tbl_care  [N_CUBE];
    logic [N_IN-1:0]  tbl_val   [N_CUBE];
    logic [N_OUT-1:0] tbl_omask [N_CUBE];

    logic              s1_valid;
    logic [N_CUBE-1:0] s1_hit;
    logic [N_OUT-1:0]  s1_omask [N_CUBE];

    logic              out_valid_q;
    logic [N_OUT-1:0]  out_y_q;
    logic [15:0]       eval_cnt_q;

    logic              s2_ready;
    logic              s1_advance;
    logic              in_ready_w;
    logic              in_fire;
    logic              cfg_ready_w;
    logic              addr_ok;
    logic              cfg_fire;
    logic              out_fire;
    logic [N_IN-1:0]   x_eff;
    logic [N_CUBE-1:0] hit_next;
    logic [N_OUT-1:0]  y_next;

    // Elastic handshake: a stage loads when empty or when its successor
    // drains it. Input transfers take priority over table writes, so a
    // write is only accepted in cycles where no vector is transferred.
    assign s2_ready    = ~out_valid_q | bus.out_ready;
    assign s1_advance  = s1_valid & s2_ready;
    assign in_ready_w  = ~s1_valid | s1_advance;
    assign in_fire     = bus.in_valid & in_ready_w;
    assign cfg_ready_w = ~bus.in_valid | ~in_ready_w;
    assign addr_ok     = int'(bus.cfg_addr) < N_CUBE;
    assign cfg_fire    = bus.cfg_we & cfg_ready_w & addr_ok;
    assign out_fire    = out_valid_q & bus.out_ready;

    assign bus.in_ready  = in_ready_w;
    assign bus.cfg_ready = cfg_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.eval_cnt  = eval_cnt_q;

`ifdef RESTRICT_EN
    assign x_eff = (bus.in_x & ~bus.rs_mask) | (bus.rs_val & bus.rs_mask);
`else
    assign x_eff = bus.in_x;
`endif

    // AND plane: a cube hits when every cared-for literal matches.
    always_comb begin
        hit_next = '0;
        for (int i = 0; i < N_CUBE; i++) begin
            hit_next[i] = ((x_eff ^ tbl_val[i]) & tbl_care[i]) == '0;
        end
    end

    // OR plane on the stage-1 snapshot, so later table writes cannot leak
    // into a vector that is already in flight.
    always_comb begin
        y_next = '0;
        for (int k = 0; k < N_OUT; k++) begin
            for (int i = 0; i < N_CUBE; i++) begin
                y_next[k] = y_next[k] | (s1_hit[i] & s1_omask[i][k]);
            end
        end
    end

    // Cube table; out-of-range addresses are silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CUBE; i++) begin
                tbl_care[i]  <= '0;
                tbl_val[i]   <= '0;
                tbl_omask[i] <= '0;
            end
        end else if (cfg_fire) begin
            tbl_care[bus.cfg_addr]  <= bus.cfg_care;
            tbl_val[bus.cfg_addr]   <= bus.cfg_val;
            tbl_omask[bus.cfg_addr] <= bus.cfg_omask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            for (int i = 0; i < N_CUBE; i++) begin
                s1_omask[i] <= '0;
            end
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_hit   <= hit_next;
            s1_omask <= tbl_omask;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 only moves when the consumer is ready or the slot is empty,
    // which keeps out_y stable during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_y_q <= y_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt_q <= '0;
        end else if (out_fire) begin
            eval_cnt_q <= eval_cnt_q + 16'd1;
        end
    end

endmodule
